// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module : serializer_pkg
// Brief  : FSM state encoding and serial-length decode helpers for par_serializer.
// Rev    : 1.0
// ============================================================================
package serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // A length field of zero selects the full word width.
    function automatic int unsigned eff_len(input int unsigned mod_val,
                                            input int unsigned data_w);
        return (mod_val == 0) ? data_w : mod_val;
    endfunction

    function automatic logic len_legal(input int unsigned len,
                                       input int unsigned min_len);
        return (len >= min_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// ============================================================================
// Module : ser_shift_reg
// Brief  : Loadable shift register presenting one serial bit, MSB- or LSB-first.
// Rev    : 1.0
// ============================================================================
module ser_shift_reg #(
    parameter int DATA_W    = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              shift_i,
    output logic              ser_o
);

    logic [DATA_W-1:0] sreg_q;
    logic [DATA_W-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            if (LSB_FIRST) begin
                sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
            end else begin
                sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    generate
        if (LSB_FIRST) begin : g_lsb_out
            assign ser_o = sreg_q[0];
        end else begin : g_msb_out
            assign ser_o = sreg_q[DATA_W-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/par_serializer.sv
`default_nettype none
// ============================================================================
// Module : par_serializer
// Brief  : Parallel-to-serial converter with one-word hold buffer and variable
//          length. Define SERIALIZER_BACKPRESSURE_EN to add the ser_rdy_i sink stall.
// Rev    : 1.0
// ============================================================================
module par_serializer
    import serializer_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int MIN_LEN   = 3,
    parameter  bit LSB_FIRST = 1'b0,
    localparam int MOD_W     = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
`ifdef SERIALIZER_BACKPRESSURE_EN
    input  logic              ser_rdy_i,
`endif
    output logic              busy_o
);

    localparam int CNT_W = MOD_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [CNT_W-1:0]  hold_len_q, hold_len_d;

    logic              transfer;
    logic              last_xfer;
    logic              accept;
    logic [CNT_W-1:0]  in_len;
    logic              in_legal;
    logic              load_from_hold;
    logic              load_direct;
    logic              to_hold;
    logic              sh_load;
    logic [DATA_W-1:0] sh_data;

    assign in_len   = CNT_W'(eff_len(32'(data_mod_i), DATA_W));
    assign in_legal = len_legal(32'(in_len), MIN_LEN);

`ifdef SERIALIZER_BACKPRESSURE_EN
    assign transfer = (state_q == ST_SHIFT) && ser_rdy_i;
`else
    assign transfer = (state_q == ST_SHIFT);
`endif

    assign last_xfer = transfer && (cnt_q == CNT_W'(1));
    assign accept    = data_val_i && data_rdy_o;

    // Illegal-length words are consumed here and never reach hold or shifter.
    assign load_from_hold = last_xfer && hold_full_q;
    assign load_direct    = accept && in_legal &&
                            ((state_q == ST_IDLE) || (last_xfer && !hold_full_q));
    assign to_hold        = accept && in_legal && !load_direct;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_len_d  = hold_len_q;
        sh_load     = 1'b0;
        sh_data     = data_i;

        if (load_from_hold) begin
            sh_load     = 1'b1;
            sh_data     = hold_data_q;
            cnt_d       = hold_len_q;
            hold_full_d = 1'b0;
            state_d     = ST_SHIFT;
        end else if (load_direct) begin
            sh_load = 1'b1;
            cnt_d   = in_len;
            state_d = ST_SHIFT;
        end else if (transfer && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (last_xfer) begin
                state_d = ST_IDLE;
            end
        end

        if (to_hold) begin
            hold_full_d = 1'b1;
            hold_data_d = data_i;
            hold_len_d  = in_len;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_len_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_len_q  <= hold_len_d;
        end
    end

    ser_shift_reg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .load_i  (sh_load),
        .data_i  (sh_data),
        .shift_i (transfer && !sh_load),
        .ser_o   (ser_data_o)
    );

    assign ser_data_val_o = (state_q == ST_SHIFT);
    assign data_rdy_o     = !hold_full_q;
    assign busy_o         = (state_q == ST_SHIFT) || hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_par_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_par_serializer
// Brief  : Scoreboard bench for par_serializer (MSB-first and LSB-first instances).
// Rev    : 1.0
// ============================================================================
module tb_par_serializer;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] data;
    logic [3:0]  mod;
    logic        val;
    logic        rdy, ser, ser_val, busy;
    logic        ser_rdy;

    logic [15:0] l_data;
    logic [3:0]  l_mod;
    logic        l_val;
    logic        l_rdy, l_ser, l_ser_val, l_busy;

    par_serializer #(.DATA_W(16), .MIN_LEN(3), .LSB_FIRST(1'b0)) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .data_i         (data),
        .data_mod_i     (mod),
        .data_val_i     (val),
        .data_rdy_o     (rdy),
        .ser_data_o     (ser),
        .ser_data_val_o (ser_val),
`ifdef SERIALIZER_BACKPRESSURE_EN
        .ser_rdy_i      (ser_rdy),
`endif
        .busy_o         (busy)
    );

    par_serializer #(.DATA_W(16), .MIN_LEN(3), .LSB_FIRST(1'b1)) dut_lsb (
        .clk_i          (clk),
        .arst_i         (arst),
        .data_i         (l_data),
        .data_mod_i     (l_mod),
        .data_val_i     (l_val),
        .data_rdy_o     (l_rdy),
        .ser_data_o     (l_ser),
        .ser_data_val_o (l_ser_val),
`ifdef SERIALIZER_BACKPRESSURE_EN
        .ser_rdy_i      (1'b1),
`endif
        .busy_o         (l_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit q_msb[$];
    bit q_lsb[$];
    int val_cnt  = 0;
    int rise_cnt = 0;
    logic prev_val = 1'b0;

    // Scoreboard pop: a bit is consumed whenever valid (and sink ready) is seen.
    always @(negedge clk) begin
        bit e;
        if (!arst && ser_val && ser_rdy) begin
            n_checks++;
            if (q_msb.size() == 0) begin
                n_fail++;
                $display("FAIL msb_extra_bit: got %0b, none expected", ser);
            end else begin
                e = q_msb.pop_front();
                if (ser !== e) begin
                    n_fail++;
                    $display("FAIL msb_bit: got %0b, expected %0b", ser, e);
                end
            end
            val_cnt++;
        end
        if (ser_val && !prev_val) rise_cnt++;
        prev_val = ser_val;
    end

    always @(negedge clk) begin
        bit e;
        if (!arst && l_ser_val) begin
            n_checks++;
            if (q_lsb.size() == 0) begin
                n_fail++;
                $display("FAIL lsb_extra_bit: got %0b, none expected", l_ser);
            end else begin
                e = q_lsb.pop_front();
                if (l_ser !== e) begin
                    n_fail++;
                    $display("FAIL lsb_bit: got %0b, expected %0b", l_ser, e);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_msb(input logic [15:0] d, input logic [3:0] m);
        int len;
        int waits;
        len = (m == 0) ? 16 : int'(m);
        if (len >= 3) for (int i = 0; i < len; i++) q_msb.push_back(d[15-i]);
        data = d; mod = m; val = 1'b1;
        waits = 0;
        while (!rdy && waits < 100) begin @(posedge clk); #1; waits++; end
        n_checks++;
        if (waits >= 100) begin
            n_fail++;
            $display("FAIL send_msb_timeout: rdy=%0b after %0d cycles, expected 1", rdy, waits);
        end
        @(posedge clk); #1;
        val = 1'b0;
    endtask

    task automatic send_lsb(input logic [15:0] d, input logic [3:0] m);
        int len;
        int waits;
        len = (m == 0) ? 16 : int'(m);
        if (len >= 3) for (int i = 0; i < len; i++) q_lsb.push_back(d[i]);
        l_data = d; l_mod = m; l_val = 1'b1;
        waits = 0;
        while (!l_rdy && waits < 100) begin @(posedge clk); #1; waits++; end
        n_checks++;
        if (waits >= 100) begin
            n_fail++;
            $display("FAIL send_lsb_timeout: rdy=%0b after %0d cycles, expected 1", l_rdy, waits);
        end
        @(posedge clk); #1;
        l_val = 1'b0;
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while ((q_msb.size() != 0 || q_lsb.size() != 0 || busy || l_busy) && waits < 300) begin
            @(posedge clk); #1; waits++;
        end
        n_checks++;
        if (waits >= 300) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d msb and %0d lsb bits outstanding, expected 0",
                     q_msb.size(), q_lsb.size());
        end
    endtask

    task automatic test_reset();
        #2 arst = 1'b1;
        #1;
        n_checks += 4;
        if (ser !== 1'b0)     begin n_fail++; $display("FAIL reset_ser: got %b, expected 0", ser); end
        if (ser_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b, expected 0", ser_val); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (rdy !== 1'b1)     begin n_fail++; $display("FAIL reset_rdy: got %b, expected 1", rdy); end
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        int v0, r0;
        v0 = val_cnt; r0 = rise_cnt;
        send_msb(16'hA5C3, 4'd0);
        n_checks += 2;
        if (ser_val !== 1'b1) begin n_fail++; $display("FAIL latency_val: got %b, expected 1", ser_val); end
        if (ser !== 1'b1)     begin n_fail++; $display("FAIL latency_bit: got %b, expected 1", ser); end
        drain();
        n_checks += 2;
        if (val_cnt - v0 != 16) begin n_fail++; $display("FAIL full_len: got %0d, expected 16", val_cnt - v0); end
        if (rise_cnt - r0 != 1) begin n_fail++; $display("FAIL full_rises: got %0d, expected 1", rise_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        int v0, r0;
        v0 = val_cnt; r0 = rise_cnt;
        send_msb(16'hF800, 4'd5);
        send_msb(16'h9000, 4'd4);
        n_checks += 2;
        if (rdy !== 1'b0)  begin n_fail++; $display("FAIL b2b_held_rdy: got %b, expected 0", rdy); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b, expected 1", busy); end
        drain();
        n_checks += 3;
        if (val_cnt - v0 != 9)  begin n_fail++; $display("FAIL b2b_len: got %0d, expected 9", val_cnt - v0); end
        if (rise_cnt - r0 != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d rises, expected 1", rise_cnt - r0); end
        if (rdy !== 1'b1)       begin n_fail++; $display("FAIL b2b_rdy_after: got %b, expected 1", rdy); end
    endtask

    task automatic test_min_len();
        int v0;
        v0 = val_cnt;
        send_msb(16'hFFFF, 4'd2);
        n_checks += 3;
        if (rdy !== 1'b1)     begin n_fail++; $display("FAIL drop_rdy: got %b, expected 1", rdy); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL drop_busy: got %b, expected 0", busy); end
        if (ser_val !== 1'b0) begin n_fail++; $display("FAIL drop_val: got %b, expected 0", ser_val); end
        send_msb(16'hFFFF, 4'd1);
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (val_cnt != v0) begin n_fail++; $display("FAIL drop_len: got %0d, expected 0", val_cnt - v0); end
        send_msb(16'h6000, 4'd3);
        drain();
        n_checks++;
        if (val_cnt - v0 != 3) begin n_fail++; $display("FAIL minlen_len: got %0d, expected 3", val_cnt - v0); end
    endtask

    task automatic test_bypass();
        int v0, r0;
        v0 = val_cnt; r0 = rise_cnt;
        send_msb(16'hC000, 4'd4);
        repeat (3) @(posedge clk);
        #1;
        send_msb(16'hA000, 4'd4);
        n_checks += 2;
        if (rdy !== 1'b1)     begin n_fail++; $display("FAIL bypass_rdy: got %b, expected 1", rdy); end
        if (ser_val !== 1'b1) begin n_fail++; $display("FAIL bypass_val: got %b, expected 1", ser_val); end
        drain();
        n_checks += 2;
        if (val_cnt - v0 != 8)  begin n_fail++; $display("FAIL bypass_len: got %0d, expected 8", val_cnt - v0); end
        if (rise_cnt - r0 != 1) begin n_fail++; $display("FAIL bypass_gap: got %0d rises, expected 1", rise_cnt - r0); end
    endtask

    task automatic test_lsb_first();
        send_lsb(16'h0001, 4'd3);
        drain();
        send_lsb(16'hA5C3, 4'd0);
        drain();
    endtask

    task automatic test_reset_mid();
        int v0;
        send_msb(16'hA5C3, 4'd0);
        repeat (6) @(posedge clk);
        #2 arst = 1'b1;
        #1;
        q_msb.delete();
        n_checks += 4;
        if (ser_val !== 1'b0) begin n_fail++; $display("FAIL midrst_val: got %b, expected 0", ser_val); end
        if (ser !== 1'b0)     begin n_fail++; $display("FAIL midrst_ser: got %b, expected 0", ser); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        if (rdy !== 1'b1)     begin n_fail++; $display("FAIL midrst_rdy: got %b, expected 1", rdy); end
        @(posedge clk);
        #1 arst = 1'b0;
        v0 = val_cnt;
        repeat (20) @(posedge clk); #1;
        n_checks++;
        if (val_cnt != v0) begin n_fail++; $display("FAIL midrst_residual: got %0d bits, expected 0", val_cnt - v0); end
        send_msb(16'h3C5A, 4'd0);
        drain();
        n_checks++;
        if (val_cnt - v0 != 16) begin n_fail++; $display("FAIL midrst_next_len: got %0d, expected 16", val_cnt - v0); end
    endtask

`ifdef SERIALIZER_BACKPRESSURE_EN
    task automatic test_backpressure();
        int   v0;
        logic b;
        v0 = val_cnt;
        send_msb(16'hA5C3, 4'd0);
        send_msb(16'h5A3C, 4'd0);
        repeat (2) @(posedge clk); #1;
        ser_rdy = 1'b0;
        b = ser;
        n_checks++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL bp_held_rdy: got %b, expected 0", rdy); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks += 2;
            if (ser !== b)        begin n_fail++; $display("FAIL bp_frozen_bit: got %b, expected %b", ser, b); end
            if (ser_val !== 1'b1) begin n_fail++; $display("FAIL bp_frozen_val: got %b, expected 1", ser_val); end
        end
        ser_rdy = 1'b1;
        drain();
        n_checks++;
        if (val_cnt - v0 != 32) begin n_fail++; $display("FAIL bp_len: got %0d, expected 32", val_cnt - v0); end
    endtask
`endif

    initial begin
        data = '0; mod = '0; val = 1'b0; ser_rdy = 1'b1;
        l_data = '0; l_mod = '0; l_val = 1'b0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_min_len();
        test_bypass();
        test_lsb_first();
        test_reset_mid();
`ifdef SERIALIZER_BACKPRESSURE_EN
        test_backpressure();
`endif
        n_checks++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d msb, %0d lsb bits never seen, expected 0", q_msb.size(), q_lsb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
